// File: rtl/cdr_tx_serializer.sv
// Framed NRZ serializer for a CDR link: alternating preamble, 8'hD5 sync word,
// then either handshaked payload bytes (MSB first) or a PRBS7 stream.
module cdr_tx_serializer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] bit_div,
    input  logic       start,
    input  logic       prbs_en,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx_out,
    output logic       tx_active
);

    typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, DATA, PRBS} state_t;

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [7:0] div_q, div_d;
    logic [7:0] shift_q, shift_d;
    logic [3:0] idx_q, idx_d;
    logic [6:0] lfsr_q, lfsr_d;
    logic       prbs_q, prbs_d;
    logic       tx_d, active_d;
    logic       strobe;

    assign strobe   = (state_q != IDLE) && (timer_q == div_q);
    assign in_ready = strobe && !prbs_q && (idx_q == 4'd7) &&
                      ((state_q == SYNC) || (state_q == DATA));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= 8'd0;
            div_q     <= 8'd0;
            shift_q   <= 8'd0;
            idx_q     <= 4'd0;
            lfsr_q    <= 7'h7F;
            prbs_q    <= 1'b0;
            tx_out    <= 1'b0;
            tx_active <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            div_q     <= div_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            lfsr_q    <= lfsr_d;
            prbs_q    <= prbs_d;
            tx_out    <= tx_d;
            tx_active <= active_d;
        end
    end

    // Every transition away from the current bit happens on the strobe, so
    // tx_out always changes exactly at a bit boundary.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        div_d    = div_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        lfsr_d   = lfsr_q;
        prbs_d   = prbs_q;
        tx_d     = tx_out;
        active_d = tx_active;

        if (state_q != IDLE) begin
            timer_d = strobe ? 8'd0 : timer_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = PREAMBLE;
                    div_d    = bit_div;
                    prbs_d   = prbs_en;
                    timer_d  = 8'd0;
                    idx_d    = 4'd0;
                    lfsr_d   = 7'h7F;
                    tx_d     = 1'b1;
                    active_d = 1'b1;
                end
            end
            PREAMBLE: begin
                if (strobe) begin
                    if (idx_q == 4'd15) begin
                        state_d = SYNC;
                        idx_d   = 4'd0;
                        shift_d = 8'hD5;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        tx_d  = idx_q[0];
                    end
                end
            end
            SYNC, DATA: begin
                if (strobe) begin
                    if (idx_q != 4'd7) begin
                        idx_d   = idx_q + 4'd1;
                        shift_d = {shift_q[6:0], 1'b0};
                        tx_d    = shift_q[6];
                    end else if (prbs_q) begin
                        state_d = PRBS;
                        idx_d   = 4'd0;
                        tx_d    = lfsr_q[6];
                    end else if (in_valid) begin
                        state_d = DATA;
                        idx_d   = 4'd0;
                        shift_d = in_data;
                        tx_d    = in_data[7];
                    end else begin
                        state_d  = IDLE;
                        idx_d    = 4'd0;
                        tx_d     = 1'b0;
                        active_d = 1'b0;
                    end
                end
            end
            PRBS: begin
                // The bit leaving the LFSR next is bit 5 of the current state.
                if (strobe) begin
                    if (!start) begin
                        state_d  = IDLE;
                        tx_d     = 1'b0;
                        active_d = 1'b0;
                    end else begin
                        lfsr_d = {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
                        tx_d   = lfsr_q[5];
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cdr_tx_serializer.sv
// Scoreboard bench for cdr_tx_serializer: a frame model fills a per-clock
// expectation queue, a negedge monitor compares the line and re-samples bytes.
module tb_cdr_tx_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] bit_div = 8'd0;
    logic [7:0] in_data = 8'd0;
    logic       start = 1'b0;
    logic       prbs_en = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready, tx_out, tx_active;

    int         checks = 0;
    int         errors = 0;
    bit         exp_q[$];
    logic [7:0] exp_bytes_q[$];
    bit         rx_bits[$];
    logic [7:0] stim_bytes[8];
    int         cur_div = 0;
    bit         cur_prbs = 1'b0;
    bit         mon_en = 1'b0;
    bit         mon_prev = 1'b0;
    int         act_cnt = 0;

    cdr_tx_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .bit_div   (bit_div),
        .start     (start),
        .prbs_en   (prbs_en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .tx_out    (tx_out),
        .tx_active (tx_active)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference frame: preamble 1010.., D5 MSB first, then bytes or PRBS7
    // where the output sequence obeys s[n+7] = s[n] ^ s[n+1] from all-ones.
    task automatic pushFrame(input int div, input bit prbs, input int nbytes, input int pbits);
        bit         b[$];
        bit         p[$];
        logic [7:0] sync;
        logic [7:0] v;
        sync = 8'hD5;
        for (int i = 0; i < 16; i++) b.push_back((i % 2) == 0);
        for (int i = 7; i >= 0; i--) b.push_back(sync[i]);
        if (prbs) begin
            for (int i = 0; i < pbits; i++) begin
                if (i < 7) p.push_back(1'b1);
                else p.push_back(p[i-7] ^ p[i-6]);
                b.push_back(p[i]);
            end
        end else begin
            for (int k = 0; k < nbytes; k++) begin
                v = stim_bytes[k];
                exp_bytes_q.push_back(v);
                for (int i = 7; i >= 0; i--) b.push_back(v[i]);
            end
        end
        foreach (b[i]) repeat (div + 1) exp_q.push_back(b[i]);
    endtask

    task automatic rxFrameEnd();
        logic [7:0] v;
        int         nb;
        v = 8'd0;
        for (int i = 16; i < 24 && i < rx_bits.size(); i++) v = {v[6:0], rx_bits[i]};
        checkOutput("rx_sync", v, 8'hD5);
        if (!cur_prbs) begin
            nb = (rx_bits.size() >= 24) ? (rx_bits.size() - 24) / 8 : 0;
            for (int k = 0; k < nb; k++) begin
                for (int i = 0; i < 8; i++) v = {v[6:0], rx_bits[24 + 8*k + i]};
                if (exp_bytes_q.size() == 0) checkOutput("rx_extra_byte", v, 32'hFFFF_FFFF);
                else checkOutput("rx_byte", v, exp_bytes_q.pop_front());
            end
        end
        rx_bits.delete();
    endtask

    // Line monitor plus a receiver sampling mid-bit at the nominal ratio.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tx_active) begin
                if (exp_q.size() == 0) checkOutput("extra_bit", tx_out, 32'hFFFF_FFFF);
                else checkOutput("tx_bit", tx_out, exp_q.pop_front());
                if ((act_cnt % (cur_div + 1)) == (cur_div / 2)) rx_bits.push_back(tx_out);
                act_cnt++;
            end else begin
                checkOutput("idle_line", tx_out, 0);
                if (mon_prev) rxFrameEnd();
                act_cnt = 0;
            end
            mon_prev = tx_active;
        end
    end

    // Runs nframes frames; nframes=2 keeps start high to test back-to-back restart.
    task automatic applyStimulus(input int div, input bit prbs, input int nbytes,
                                 input int pbits, input int nframes);
        int  cycles, falls, ptr, rdy, xfer, lower_at;
        bit  prev, xfer_now;
        cycles = 0; falls = 0; ptr = 0; rdy = 0; xfer = 0; prev = 1'b0;
        lower_at = 1 + (23 + pbits) * (div + 1);
        cur_div = div;
        cur_prbs = prbs;
        for (int f = 0; f < nframes; f++) pushFrame(div, prbs, nbytes, pbits);
        bit_div = 8'(div);
        prbs_en = prbs;
        start = 1'b1;
        in_valid = (nbytes > 0) ? 1'b1 : (prbs ? 1'($urandom_range(0, 1)) : 1'b0);
        in_data = (nbytes > 0) ? stim_bytes[0] : 8'($urandom);
        forever begin
            @(negedge clk);
            xfer_now = 1'b0;
            if (in_ready) begin
                rdy++;
                if (in_valid) begin
                    xfer++;
                    xfer_now = 1'b1;
                end
            end
            if (cycles == 1) begin
                checkOutput("first_bit_active", tx_active, 1);
                checkOutput("first_bit_value", tx_out, 1);
            end
            if (prev && !tx_active) falls++;
            prev = tx_active;
            if (falls >= nframes) break;
            if (cycles > 6000) begin
                checkOutput("frame_timeout", cycles, 0);
                break;
            end
            @(posedge clk);
            cycles++;
            #1;
            if (xfer_now) ptr++;
            if (!prbs) begin
                in_valid = (ptr < nbytes);
                in_data = (ptr < nbytes) ? stim_bytes[ptr] : 8'($urandom);
            end
            if (nframes == 1) begin
                if (!prbs || cycles == lower_at) start = 1'b0;
                bit_div = 8'($urandom);
                prbs_en = 1'($urandom_range(0, 1));
            end else if (falls >= 1) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("in_ready_pulses", rdy, prbs ? 0 : nframes * (nbytes + 1));
        checkOutput("transfers", xfer, prbs ? 0 : nframes * nbytes);
        checkOutput("frame_length_left", exp_q.size(), 0);
        checkOutput("rx_bytes_left", exp_bytes_q.size(), 0);
        exp_q.delete();
        exp_bytes_q.delete();
    endtask

    task automatic resetMidFrame();
        mon_en = 1'b0;
        start = 1'b1; bit_div = 8'd2; prbs_en = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A;
        @(posedge clk);
        #1;
        start = 1'b0;
        bit_div = 8'd7;
        repeat (81) @(posedge clk);
        #1;
        checkOutput("mid_data_active", tx_active, 1);
        rst = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_tx_out", tx_out, 0);
        checkOutput("rst_tx_active", tx_active, 0);
        checkOutput("rst_in_ready", in_ready, 0);
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("no_autostart", tx_active, 0);
        mon_prev = 1'b0;
        act_cnt = 0;
        rx_bits.delete();
        mon_en = 1'b1;
    endtask

    initial begin
        $display("[TB] cdr_tx_serializer bench start");
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_tx_out", tx_out, 0);
        checkOutput("reset_tx_active", tx_active, 0);
        checkOutput("reset_in_ready", in_ready, 0);
        rst = 1'b0;
        mon_en = 1'b1;

        stim_bytes[0] = 8'hA5; stim_bytes[1] = 8'hA5;
        applyStimulus(3, 1'b0, 2, 0, 1);
        applyStimulus(0, 1'b0, 0, 0, 1);
        applyStimulus(0, 1'b1, 0, 40, 1);
        stim_bytes[0] = 8'h00; stim_bytes[1] = 8'hFF; stim_bytes[2] = 8'h3C;
        applyStimulus(1, 1'b0, 3, 0, 1);
        applyStimulus(0, 1'b0, 0, 0, 2);
        resetMidFrame();
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) stim_bytes[i] = 8'($urandom);
            applyStimulus($urandom_range(0, 4), 1'($urandom_range(0, 1)),
                          $urandom_range(0, 3), $urandom_range(1, 20), 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdr_tx_serializer.md
CDR_TX_SERIALIZER -- requirements
Module: cdr_tx_serializer

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all logic rising-edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: bit_div  input  8  clocks per bit minus 1; sampled on accepted start.
REQ-004 SHALL have port: start  input  1  level; frame request when IDLE.
REQ-005 SHALL have port: prbs_en  input  1  sampled with start; 1 = PRBS7 payload, 0 = byte payload.
REQ-006 SHALL have port: in_data  input  8  payload byte, sent MSB first.
REQ-007 SHALL have port: in_valid  input  1  in_data valid.
REQ-008 SHALL have port: in_ready  output  1  byte accepted when in_valid && in_ready.
REQ-009 SHALL have port: tx_out  output  1  registered NRZ serial line to the CDR receiver.
REQ-010 SHALL have port: tx_active  output  1  high while a frame is on the line.

Function
REQ-011 SHALL implement states IDLE, PREAMBLE, SYNC, DATA, PRBS.
REQ-012 SHALL stay in IDLE while start=0; tx_out=0, tx_active=0.
REQ-013 SHALL, on start=1 in IDLE at cycle N, latch bit_div and prbs_en, enter PREAMBLE, and drive the first preamble bit on tx_out in cycle N+1.
REQ-014 SHALL hold each bit for exactly bit_div+1 clocks; bit_div=0 gives one bit per clock.
REQ-015 SHALL use an 8-bit bit timer counting 0..latched bit_div; bit strobe when count equals latched bit_div, then wrap to 0.
REQ-016 SHALL ignore bit_div, prbs_en and start changes in any non-IDLE state, except as given in REQ-021.
REQ-017 SHALL send PREAMBLE as 16 bits alternating 1,0,..., starting with 1, then enter SYNC.
REQ-018 SHALL send SYNC as 8'hD5 MSB first, then enter DATA (prbs_en=0) or PRBS (prbs_en=1).
REQ-019 SHALL assert in_ready for exactly one clock: the bit-strobe cycle of bit 7 of SYNC or DATA, when latched prbs_en=0; in_ready=0 at all other times.
REQ-020 SHALL, on transfer in that cycle, load in_data and continue in DATA with no idle bit; SHALL, with in_valid=0 in that cycle, return to IDLE next clock (tx_out=0, tx_active=0). A SYNC with no following byte is a legal empty frame.
REQ-021 SHALL in PRBS send PRBS7 (x^7+x^6+1, seed 7'h7F at frame start, output = LFSR bit 6, shift on bit strobe), and return to IDLE at the first bit strobe with start=0.
REQ-022 SHALL keep tx_active=1 from the first preamble bit through the last bit period of the frame.
REQ-023 SHALL accept a new start only in IDLE; start held high SHALL begin a new frame the cycle after IDLE is re-entered.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, force state IDLE, tx_out=0, tx_active=0, in_ready=0, timer=0, bit index=0, LFSR=7'h7F, latched bit_div=0, latched prbs_en=0.
REQ-025 SHALL give rst priority over all other inputs, including mid-frame; the first frame after reset needs start while IDLE.

Verification
REQ-026 Bench SHALL: rst 2 cycles, then start=1, bit_div=3, prbs_en=0, in_data=8'hA5 held valid -> tx_out 4 clocks/bit: 1010...(16), 11010101, 10100101; in_ready single pulse at each byte boundary.
REQ-027 Bench SHALL: bit_div=0, prbs_en=0, in_valid=0 -> 24 bits (preamble + D5) one per clock, then tx_active falls and tx_out=0; in_ready pulses once, not accepted.
REQ-028 Bench SHALL: bit_div=0, prbs_en=1, start high for 40 bits -> after SYNC, tx_out matches PRBS7 reference from seed 7F (first 7 bits 1111111, then 0000001); stops at the next strobe after start falls.
REQ-029 Bench SHALL: bytes 8'h00, 8'hFF, 8'h3C back-to-back at bit_div=1 -> no gap between bytes; exactly three in_ready/in_valid transfers; frame ends after 3C.
REQ-030 Bench SHALL: rst=1 mid-DATA -> next clock tx_out=0, tx_active=0, in_ready=0; bit_div change mid-frame leaves bit period unchanged.
REQ-031 Bench SHALL: loop tx_out into the CDR receiver's serial input at its nominal oversampling ratio -> recovered bytes equal transmitted bytes.
